// File: rtl/tfacc_pkg.sv
// Shared constants and types for the TFACC read-path arbiter.
package tfacc_pkg;

  localparam logic [2:0] SIZE_16B   = 3'b100;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [3:0] CACHE_BUF  = 4'b0011;

  localparam int ADDR_W = 40;
  localparam int LEN_W  = 8;
  localparam int IDX_W  = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } rd_state_e;

  // Next round-robin start point: one past the granted index, wrapping at n.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
    logic [IDX_W-1:0] nxt_v;
    if (int'(idx) >= n - 1) begin
      nxt_v = {IDX_W{1'b0}};
    end else begin
      nxt_v = idx + {{(IDX_W-1){1'b0}}, 1'b1};
    end
    return nxt_v;
  endfunction

endpackage

// File: rtl/tfacc_rd_arb_rr_arb.sv
// Round-robin priority encoder: picks the first requester at or above ptr, wrapping.
module rr_arb
  import tfacc_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             any
);

  int off_s;
  int best_off_s;

  // Smallest rotated distance from ptr wins.
  always_comb begin
    grant      = ptr;
    any        = 1'b0;
    best_off_s = NREQ;
    off_s      = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      off_s = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + NREQ - int'(ptr));
      if (req[i] && (off_s < best_off_s)) begin
        best_off_s = off_s;
        grant      = IDX_W'(i);
        any        = 1'b1;
      end else begin
        best_off_s = best_off_s;
      end
    end
  end

endmodule

// File: rtl/tfacc_rd_arb.sv
// Multi-requester AXI4 read arbiter: round-robin AR issue with an outstanding-burst
// limit, and per-beat R routing back to the requester named by RID.
module tfacc_rd_arb
  import tfacc_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int MAXOUT = 8
) (
  input  logic                   cclk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*LEN_W-1:0]  req_len,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [127:0]           rsp_data,
  output logic                   rsp_last,
  output logic [3:0]             M00_AXI_ARID,
  output logic [ADDR_W-1:0]      M00_AXI_ARADDR,
  output logic [LEN_W-1:0]       M00_AXI_ARLEN,
  output logic [2:0]             M00_AXI_ARSIZE,
  output logic [1:0]             M00_AXI_ARBURST,
  output logic                   M00_AXI_ARLOCK,
  output logic [3:0]             M00_AXI_ARCACHE,
  output logic [2:0]             M00_AXI_ARPROT,
  output logic [3:0]             M00_AXI_ARQOS,
  output logic                   M00_AXI_ARVALID,
  input  logic                   M00_AXI_ARREADY,
  input  logic [3:0]             M00_AXI_RID,
  input  logic [127:0]           M00_AXI_RDATA,
  input  logic [1:0]             M00_AXI_RRESP,
  input  logic                   M00_AXI_RLAST,
  input  logic                   M00_AXI_RVALID,
  output logic                   M00_AXI_RREADY,
  output logic [3:0]             outstanding,
  output logic                   err
);

  localparam logic [3:0] MAXOUT_C = 4'(MAXOUT);

  rd_state_e          state_r;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [IDX_W-1:0]   gnt_idx_r;
  logic [NREQ-1:0]    req_ready_r;
  logic               arvalid_r;
  logic [ADDR_W-1:0]  araddr_r;
  logic [LEN_W-1:0]   arlen_r;
  logic [3:0]         arid_r;
  logic [3:0]         outstanding_r;
  logic               err_r;

  logic [IDX_W-1:0]   gnt_s;
  logic               any_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic [LEN_W-1:0]   sel_len_s;
  logic               ar_hs_s;
  logic               r_last_hs_s;
  logic               rid_ok_s;
  logic               rready_s;
  logic [NREQ-1:0]    rsp_valid_s;
  logic               err_set_s;

  rr_arb #(.NREQ(NREQ)) u_rr_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_r),
    .grant (gnt_s),
    .any   (any_s)
  );

  // Select the winning requester's address and length.
  always_comb begin
    sel_addr_s = {ADDR_W{1'b0}};
    sel_len_s  = {LEN_W{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      sel_addr_s = (gnt_s == IDX_W'(i)) ? req_addr[i*ADDR_W +: ADDR_W] : sel_addr_s;
      sel_len_s  = (gnt_s == IDX_W'(i)) ? req_len[i*LEN_W +: LEN_W]    : sel_len_s;
    end
  end

  // Route each R beat by RID; unknown IDs are accepted and dropped.
  always_comb begin
    rsp_valid_s = {NREQ{1'b0}};
    rready_s    = 1'b1;
    rid_ok_s    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (M00_AXI_RID == 4'(i)) begin
        rsp_valid_s[i] = M00_AXI_RVALID;
        rready_s       = rsp_ready[i];
        rid_ok_s       = 1'b1;
      end else begin
        rid_ok_s = rid_ok_s;
      end
    end
  end

  assign ar_hs_s     = arvalid_r && M00_AXI_ARREADY;
  assign r_last_hs_s = M00_AXI_RVALID && rready_s && M00_AXI_RLAST;
  assign err_set_s   = M00_AXI_RVALID && (!rid_ok_s || (rready_s && (M00_AXI_RRESP != 2'b00)));

  // Grant/issue FSM with registered AR channel and accept strobe.
  always_ff @(posedge cclk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      rr_ptr_r    <= {IDX_W{1'b0}};
      gnt_idx_r   <= {IDX_W{1'b0}};
      req_ready_r <= {NREQ{1'b0}};
      arvalid_r   <= 1'b0;
      araddr_r    <= {ADDR_W{1'b0}};
      arlen_r     <= {LEN_W{1'b0}};
      arid_r      <= 4'b0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_s && (outstanding_r < MAXOUT_C)) begin
            req_ready_r <= {{(NREQ-1){1'b0}}, 1'b1} << gnt_s;
            gnt_idx_r   <= gnt_s;
            araddr_r    <= sel_addr_s;
            arlen_r     <= sel_len_s;
            arid_r      <= {2'b00, gnt_s};
            arvalid_r   <= 1'b1;
            state_r     <= ST_ISSUE;
          end else begin
            req_ready_r <= {NREQ{1'b0}};
          end
        end
        ST_ISSUE: begin
          req_ready_r <= {NREQ{1'b0}};
          if (ar_hs_s) begin
            arvalid_r <= 1'b0;
            rr_ptr_r  <= wrap_inc(gnt_idx_r, NREQ);
            state_r   <= ST_IDLE;
          end else begin
            arvalid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          arvalid_r   <= 1'b0;
          req_ready_r <= {NREQ{1'b0}};
        end
      endcase
    end
  end

  // In-flight burst count; saturates at zero so stray RLASTs after reset are harmless.
  always_ff @(posedge cclk) begin
    if (reset) begin
      outstanding_r <= 4'd0;
    end else begin
      case ({ar_hs_s, r_last_hs_s})
        2'b10:   outstanding_r <= outstanding_r + 4'd1;
        2'b01:   outstanding_r <= (outstanding_r != 4'd0) ? (outstanding_r - 4'd1) : outstanding_r;
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  // Sticky error flag.
  always_ff @(posedge cclk) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (err_set_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign req_ready       = req_ready_r;
  assign rsp_valid       = rsp_valid_s;
  assign rsp_data        = M00_AXI_RDATA;
  assign rsp_last        = M00_AXI_RLAST;
  assign M00_AXI_RREADY  = rready_s;
  assign M00_AXI_ARID    = arid_r;
  assign M00_AXI_ARADDR  = araddr_r;
  assign M00_AXI_ARLEN   = arlen_r;
  assign M00_AXI_ARSIZE  = SIZE_16B;
  assign M00_AXI_ARBURST = BURST_INCR;
  assign M00_AXI_ARLOCK  = 1'b0;
  assign M00_AXI_ARCACHE = CACHE_BUF;
  assign M00_AXI_ARPROT  = 3'b000;
  assign M00_AXI_ARQOS   = 4'b0000;
  assign M00_AXI_ARVALID = arvalid_r;
  assign outstanding     = outstanding_r;
  assign err             = err_r;

endmodule
